// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the 16-bit core: redirect FSM states,
// default address width and jump condition codes used by the condition evaluator.
package core_ctrl_pkg;

  localparam int DEFAULT_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } redirect_state_t;

  localparam logic [2:0] JUMP_B   = 3'd1;
  localparam logic [2:0] JUMP_BE  = 3'd2;
  localparam logic [2:0] JUMP_BLT = 3'd3;
  localparam logic [2:0] JUMP_BLE = 3'd4;
  localparam logic [2:0] JUMP_BNE = 3'd5;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with hold; stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count
);

  // count accepted increments, freezing at the maximum value
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !hold && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch mispredict redirect controller: PC redirect pulse, timed flush of
// younger stages, refill hold-off, and a saturating mispredict counter.
module branch_redirect_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int ADDR_W        = DEFAULT_ADDR_W,
  parameter int FLUSH_CYCLES  = 3,
  parameter int REFILL_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memory_waiting,
  input  logic              branch_wb,
  input  logic              jump,
  input  logic              pred_taken_wb,
  input  logic [ADDR_W-1:0] target_wb,
  input  logic [ADDR_W-1:0] fallthru_wb,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_value,
  output logic              flush_decode,
  output logic              jump_pred_busy,
  output logic [1:0]        ctrl_state,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] REFILL_INIT = 4'(REFILL_CYCLES - 1);
  localparam logic       HAS_REFILL  = (REFILL_CYCLES != 0);

  redirect_state_t   state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic              pend_r, pend_nxt_s;
  logic [ADDR_W-1:0] value_r, value_nxt_s;
  logic              flush_r, flush_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              mispredict_s;
  logic              accept_s;

  assign mispredict_s = branch_wb & (jump ^ pred_taken_wb);
  // In FLUSH the writeback slot only holds squashed bubbles, so it is not examined.
  assign accept_s     = mispredict_s & ~memory_waiting &
                        ((state_r == IDLE) | (state_r == REFILL));

  // next-state, countdown and registered-output values
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pend_nxt_s  = pend_r;
    value_nxt_s = value_r;
    flush_nxt_s = flush_r;
    busy_nxt_s  = busy_r;
    if (memory_waiting) begin
      state_nxt_s = state_r;
    end else begin
      pend_nxt_s = 1'b0;
      case (state_r)
        IDLE, REFILL: begin
          if (accept_s) begin
            state_nxt_s = FLUSH;
            cnt_nxt_s   = FLUSH_INIT;
            pend_nxt_s  = 1'b1;
            value_nxt_s = jump ? target_wb : fallthru_wb;
            flush_nxt_s = 1'b1;
            busy_nxt_s  = 1'b1;
          end else if ((state_r == REFILL) && (cnt_r != 4'd0)) begin
            cnt_nxt_s = cnt_r - 4'd1;
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
            flush_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
          end
        end
        FLUSH: begin
          if (cnt_r != 4'd0) begin
            cnt_nxt_s = cnt_r - 4'd1;
          end else if (HAS_REFILL) begin
            state_nxt_s = REFILL;
            cnt_nxt_s   = REFILL_INIT;
            flush_nxt_s = 1'b0;
            busy_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
            flush_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
          flush_nxt_s = 1'b0;
          busy_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      pend_r  <= 1'b0;
      value_r <= '0;
      flush_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pend_r  <= pend_nxt_s;
      value_r <= value_nxt_s;
      flush_r <= flush_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // A stall must neither fire nor stretch the redirect pulse.
  assign pc_load        = pend_r & ~memory_waiting;
  assign pc_load_value  = value_r;
  assign flush_decode   = flush_r;
  assign jump_pred_busy = busy_r;
  assign ctrl_state     = state_r;

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept_s),
    .hold  (memory_waiting),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed scenarios then random traffic
// checked against a countdown-of-remaining-cycles reference model.
module tb_branch_redirect_ctrl;

  localparam int AW    = 16;
  localparam int F     = 3;
  localparam int R     = 2;
  localparam int CNT_W = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          memory_waiting = 1'b0;
  logic          branch_wb = 1'b0;
  logic          jump = 1'b0;
  logic          pred_taken_wb = 1'b0;
  logic [AW-1:0] target_wb = '0;
  logic [AW-1:0] fallthru_wb = '0;
  logic          pc_load;
  logic [AW-1:0] pc_load_value;
  logic          flush_decode;
  logic          jump_pred_busy;
  logic [1:0]    ctrl_state;
  logic [CNT_W-1:0] mispredict_count;

  branch_redirect_ctrl #(
    .ADDR_W(AW), .FLUSH_CYCLES(F), .REFILL_CYCLES(R), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .memory_waiting(memory_waiting),
    .branch_wb(branch_wb), .jump(jump), .pred_taken_wb(pred_taken_wb),
    .target_wb(target_wb), .fallthru_wb(fallthru_wb),
    .pc_load(pc_load), .pc_load_value(pc_load_value),
    .flush_decode(flush_decode), .jump_pred_busy(jump_pred_busy),
    .ctrl_state(ctrl_state), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pc_load;
    logic [AW-1:0] val;
    logic          flush;
    logic          busy;
    logic [1:0]    st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: cycles of flush / busy still owed after the last redirect
  int            flush_left = 0;
  int            busy_left  = 0;
  bit            pend       = 1'b0;
  logic [AW-1:0] mval       = '0;
  int            mcount     = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  task automatic cycle(input bit bw, input bit j, input bit p,
                       input logic [AW-1:0] t, input logic [AW-1:0] f,
                       input bit mw, input bit rst);
    exp_t e;
    @(negedge clk);
    branch_wb = bw; jump = j; pred_taken_wb = p;
    target_wb = t; fallthru_wb = f; memory_waiting = mw; reset = rst;
    e.pc_load = pend && !mw;
    e.val     = mval;
    e.flush   = (flush_left > 0);
    e.busy    = (busy_left > 0);
    e.st      = (flush_left > 0) ? 2'd1 : ((busy_left > 0) ? 2'd2 : 2'd0);
    e.cnt     = CNT_W'(mcount);
    exp_q.push_back(e);
    if (rst) begin
      flush_left = 0; busy_left = 0; pend = 1'b0; mval = '0; mcount = 0;
    end else if (!mw) begin
      pend = 1'b0;
      if (bw && (j != p) && (flush_left == 0)) begin
        flush_left = F;
        busy_left  = F + R;
        pend       = 1'b1;
        mval       = j ? t : f;
        if (mcount < (2 ** CNT_W) - 1) mcount++;
      end else begin
        if (flush_left > 0) flush_left--;
        if (busy_left > 0) busy_left--;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
  endtask

  // monitor: compare every presented cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_load", {31'd0, pc_load}, {31'd0, e.pc_load});
        chk("pc_load_value", {16'd0, pc_load_value}, {16'd0, e.val});
        chk("flush_decode", {31'd0, flush_decode}, {31'd0, e.flush});
        chk("jump_pred_busy", {31'd0, jump_pred_busy}, {31'd0, e.busy});
        chk("ctrl_state", {30'd0, ctrl_state}, {30'd0, e.st});
        chk("mispredict_count", {29'd0, mispredict_count}, {29'd0, e.cnt});
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    idle(10);
    cycle(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0011, 1'b0, 1'b0);
    idle(3);
    cycle(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0041, 1'b0, 1'b0);
    idle(7);
    cycle(1'b1, 1'b0, 1'b1, 16'h0080, 16'h0011, 1'b0, 1'b0);
    idle(7);
    // stall across the second flush cycle
    cycle(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0022, 1'b0, 1'b0);
    idle(1);
    stall(4);
    idle(8);
    // stall in the first flush cycle defers the pulse
    cycle(1'b1, 1'b0, 1'b1, 16'h0abc, 16'h0033, 1'b0, 1'b0);
    stall(2);
    idle(8);
    // second mispredict in the first refill cycle
    cycle(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0044, 1'b0, 1'b0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b1, 16'h0200, 16'h0055, 1'b0, 1'b0);
    idle(8);
    // mispredict presented during flush is ignored
    cycle(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0066, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 16'h0400, 16'h0077, 1'b0, 1'b0);
    idle(6);
    // reset mid-flush
    cycle(1'b1, 1'b1, 1'b0, 16'h0500, 16'h0088, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    idle(3);
    // drive the counter into saturation
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, k[0], ~k[0], 16'(k * 3), 16'(k * 5), 1'b0, 1'b0);
      idle(5);
    end
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom % 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            16'($urandom), 16'($urandom), ($urandom % 5) == 0, ($urandom % 200) == 0);
    end
    idle(2);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
